// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter constants and state encoding.
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int UBRR_W     = 12;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversampling tick prescaler, one tick every ubrr+1 clocks.
module uart_baud_tick #(
    parameter int UBRR_W = uart_pkg::UBRR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [UBRR_W-1:0] ubrr,
    output logic              tick
);
    logic [UBRR_W-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = !clr && (cnt_q == ubrr);
        cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling 8N1 UART receiver with valid/ready output,
// frame-error and overrun pulses.
module uart_rx_os
    import uart_pkg::state_t, uart_pkg::IDLE, uart_pkg::START, uart_pkg::DATA,
           uart_pkg::STOP, uart_pkg::WAIT_HI, uart_pkg::DATA_BITS;
#(
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int UBRR_W     = uart_pkg::UBRR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [UBRR_W-1:0] ubrr,
    input  logic              rxd,
    output logic [7:0]        data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    state_t        state_q, state_d;
    logic          s1_q, s2_q, rxs;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic          tick, done, ferr;

    assign rxs = s2_q;

    // Holding the prescaler clear throughout IDLE aligns ticks to the start edge.
    uart_baud_tick #(.UBRR_W(UBRR_W)) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (state_q == IDLE),
        .ubrr(ubrr),
        .tick(tick)
    );

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done    = 1'b0;
        ferr    = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (!rxs) state_d = START;
            end
            START: if (tick) begin
                tick_d = (tick_q == HALF) ? '0 : tick_q + 1'b1;
                if (tick_q == HALF) begin
                    state_d = rxs ? IDLE : DATA;
                    bit_d   = '0;
                end
            end
            DATA: if (tick) begin
                tick_d = (tick_q == LAST) ? '0 : tick_q + 1'b1;
                if (tick_q == LAST) begin
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) state_d = STOP;
                end
            end
            STOP: if (tick) begin
                tick_d = (tick_q == LAST) ? '0 : tick_q + 1'b1;
                if (tick_q == LAST) begin
                    done    = rxs;
                    ferr    = !rxs;
                    state_d = rxs ? IDLE : WAIT_HI;
                end
            end
            WAIT_HI: if (rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A completed byte is dropped only when the held one is not consumed this clock.
    always_comb begin
        valid_d = done ? 1'b1 : (valid_q && !ready_i);
        data_d  = (done && (!valid_q || ready_i)) ? shift_q : data_q;
        ovr_d   = done && valid_q && !ready_i;
        ferr_d  = ferr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= rxd;
            s2_q    <= s1_q;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed stimulus with an expected-event queue checked by a monitor.
module tb_uart_rx_os;
    localparam int EV_BYTE = 0, EV_FERR = 1, EV_OVR = 2;
    typedef struct {int kind; logic [7:0] data;} ev_t;

    logic        clk = 0, rst = 1, rxd = 1, ready_i = 1;
    logic [11:0] ubrr = 0;
    logic [7:0]  data_o;
    logic        valid_o, frame_err_o, overrun_o, busy_o;
    int          n_chk = 0, n_fail = 0, valid_cycles = 0;
    ev_t         exp_q[$];
    logic        pv = 0, pr = 0;

    uart_rx_os dut (
        .clk(clk), .rst(rst), .ubrr(ubrr), .rxd(rxd), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .frame_err_o(frame_err_o),
        .overrun_o(overrun_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic pop_check(input int kind, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            check({name, "_unexpected"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({name, "_kind"}, kind, e.kind);
            if (kind != EV_FERR) check({name, "_data"}, data_o, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            pv <= 0;
            pr <= 0;
        end else begin
            if (valid_o) valid_cycles++;
            if (valid_o && (!pv || pr)) pop_check(EV_BYTE, "byte");
            if (frame_err_o) pop_check(EV_FERR, "frame_err");
            if (overrun_o) pop_check(EV_OVR, "overrun");
            pv <= valid_o;
            pr <= ready_i;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        int bt;
        bt = 16 * (int'(ubrr) + 1);
        rxd = 0;
        clks(bt);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            clks(bt);
        end
        rxd = stop;
        clks(bt);
    endtask

    initial begin
        int t;
        clks(3);
        check("rst_data", data_o, 8'h00);
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_ovr", overrun_o, 0);
        rst = 0;
        clks(5);

        ubrr = 0;
        valid_cycles = 0;
        push(EV_BYTE, 8'hA5);
        send(8'hA5, 1);
        clks(20);
        check("a5_valid_width", valid_cycles, 1);

        ubrr = 3;
        push(EV_BYTE, 8'h00);
        push(EV_BYTE, 8'hFF);
        send(8'h00, 1);
        send(8'hFF, 1);
        clks(80);
        check("b2b_data", data_o, 8'hFF);

        rxd = 0;
        clks(16);
        rxd = 1;
        clks(40);
        check("glitch_busy", busy_o, 0);
        check("glitch_valid", valid_o, 0);

        ubrr = 0;
        push(EV_FERR, 8'h00);
        send(8'h3C, 0);
        clks(40 * 16);
        check("break_busy", busy_o, 1);
        check("break_valid", valid_o, 0);
        rxd = 1;
        clks(10);
        check("break_release_busy", busy_o, 0);
        check("break_data_kept", data_o, 8'hFF);

        ready_i = 0;
        push(EV_BYTE, 8'h11);
        push(EV_OVR, 8'h11);
        send(8'h11, 1);
        clks(16);
        send(8'h22, 1);
        clks(20);
        check("ovr_data", data_o, 8'h11);
        check("ovr_valid_held", valid_o, 1);
        ready_i = 1;
        clks(2);
        check("ovr_valid_drop", valid_o, 0);

        rxd = 0;
        clks(16);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'(8'h5A >> i);
            clks(16);
        end
        rxd = 1'(8'h5A >> 4);
        clks(8);
        rst = 1;
        clks(2);
        check("midrst_busy", busy_o, 0);
        rst = 0;
        rxd = 1;
        clks(40);
        push(EV_BYTE, 8'hC3);
        send(8'hC3, 1);
        clks(20);
        check("midrst_data", data_o, 8'hC3);

        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            clks(1);
            t++;
        end
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
